matrix_scroll_disp: RTL and testbench

Parametrised LED dot-matrix scan controller. It drives NCOL multiplexed columns of an 8-row matrix from a double-buffered message of MSG_LEN hex glyphs, rendered through the shared 8x8 hex font. It adds three things to the single-glyph 8x8 scanner: per-column PWM brightness with a built-in anti-ghost blank phase, tear-free message updates, and horizontal scrolling with wrap-around. It sits between a CE tick generator (clock divider) and the matrix column/row drivers.

---
 rtl/matrix_disp_pkg.sv | 30 +++
 rtl/matrix_glyph_rom.sv | 12 +
 rtl/matrix_scroll_disp.sv | 165 ++++++++++++++++
 tb/tb_matrix_scroll_disp.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_disp_pkg.sv
// Shared definitions for the dot-matrix display blocks: geometry constants,
// glyph code type and the 16-glyph hex font (column-major, bit0 = top row).
package matrix_disp_pkg;

    localparam int GLYPH_W = 8;
    localparam int ROWS    = 8;

    typedef logic [3:0] glyph_t;

    // HEX_FONT[glyph][glyph column] is one column of pixels, bit0 at the top.
    localparam logic [ROWS-1:0] HEX_FONT [16][GLYPH_W] = '{
        '{8'h00, 8'h3C, 8'h42, 8'h81, 8'h81, 8'h42, 8'h3C, 8'h00},  // 0
        '{8'h00, 8'h04, 8'h02, 8'h81, 8'hFF, 8'h80, 8'h80, 8'h00},  // 1
        '{8'h00, 8'hC2, 8'hA1, 8'h91, 8'h89, 8'h86, 8'h00, 8'h00},  // 2
        '{8'h00, 8'h42, 8'h81, 8'h89, 8'h89, 8'h76, 8'h00, 8'h00},  // 3
        '{8'h00, 8'h30, 8'h28, 8'h24, 8'h22, 8'hFF, 8'h20, 8'h00},  // 4
        '{8'h00, 8'h4F, 8'h89, 8'h89, 8'h89, 8'h71, 8'h00, 8'h00},  // 5
        '{8'h00, 8'h7E, 8'h89, 8'h89, 8'h89, 8'h72, 8'h00, 8'h00},  // 6
        '{8'h00, 8'h01, 8'h01, 8'hE1, 8'h11, 8'h09, 8'h07, 8'h00},  // 7
        '{8'h00, 8'h76, 8'h89, 8'h89, 8'h89, 8'h76, 8'h00, 8'h00},  // 8
        '{8'h00, 8'h4E, 8'h91, 8'h91, 8'h91, 8'h7E, 8'h00, 8'h00},  // 9
        '{8'h00, 8'hFE, 8'h11, 8'h11, 8'h11, 8'hFE, 8'h00, 8'h00},  // A
        '{8'h00, 8'hFF, 8'h89, 8'h89, 8'h89, 8'h76, 8'h00, 8'h00},  // B
        '{8'h00, 8'h7E, 8'h81, 8'h81, 8'h81, 8'h42, 8'h00, 8'h00},  // C
        '{8'h00, 8'hFF, 8'h81, 8'h81, 8'h42, 8'h3C, 8'h00, 8'h00},  // D
        '{8'h00, 8'hFF, 8'h89, 8'h89, 8'h89, 8'h81, 8'h00, 8'h00},  // E
        '{8'h00, 8'hFF, 8'h09, 8'h09, 8'h09, 8'h01, 8'h00, 8'h00}   // F
    };

endpackage

// File: rtl/matrix_glyph_rom.sv
// Combinational font lookup: one pixel column of a hex glyph.
module matrix_glyph_rom
    import matrix_disp_pkg::*;
(
    input  glyph_t          glyph_i,
    input  logic [2:0]      gcol_i,
    output logic [ROWS-1:0] row_o
);

    assign row_o = HEX_FONT[glyph_i][gcol_i];

endmodule

// File: rtl/matrix_scroll_disp.sv
// Multiplexed LED matrix scanner with PWM dimming, double-buffered message
// and wrap-around horizontal scrolling.
module matrix_scroll_disp
    import matrix_disp_pkg::*;
#(
    parameter int NCOL        = 8,
    parameter int MSG_LEN     = 4,
    parameter int PWM_W       = 2,
    parameter int SCROLL_DIV  = 4,
    parameter bit COL_ACT_LOW = 1'b1,
    localparam int ADDR_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CE,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              commit,
    input  logic              scroll_en,
    input  logic              scroll_dir,
    input  logic [PWM_W-1:0]  brightness,
    output logic [NCOL-1:0]   column,
    output logic [ROWS-1:0]   row,
    output logic              frame_tick,
    output logic              pending
);

    localparam int COL_W  = $clog2(NCOL);
    localparam int PIX_N  = MSG_LEN * GLYPH_W;
    localparam int PIX_W  = $clog2(PIX_N);
    localparam int GCOL_W = $clog2(GLYPH_W);
    localparam int FDIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [PWM_W-1:0]  PH_MAX   = {PWM_W{1'b1}};
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NCOL - 1);
    localparam logic [FDIV_W-1:0] FDIV_MAX = FDIV_W'(SCROLL_DIV - 1);
    localparam logic [NCOL-1:0]   COL_OFF  = COL_ACT_LOW ? {NCOL{1'b1}} : '0;

    logic [PWM_W-1:0]  phase_q, phase_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [PIX_W-1:0]  offset_q, offset_d;
    logic [FDIV_W-1:0] fdiv_q, fdiv_d;
    logic              pending_q, pending_d;
    logic [PWM_W-1:0]  bright_l_q;
    logic              scroll_en_l_q;
    logic              scroll_dir_l_q;
    glyph_t            front_q [MSG_LEN];
    glyph_t            back_q  [MSG_LEN];
    logic [NCOL-1:0]   column_q, column_d;
    logic [ROWS-1:0]   row_q, row_d;
    logic              frame_tick_q;

    logic              boundary;
    logic              col_active;
    logic [PIX_W-1:0]  pix;
    logic [ADDR_W-1:0] glyph_idx;
    glyph_t            glyph;
    logic [ROWS-1:0]   rom_row;
    logic [NCOL-1:0]   col_onehot;

    assign boundary = CE && (phase_q == PH_MAX) && (col_q == COL_LAST);

    // MSG_LEN is a power of two, so the pixel index wraps by truncation.
    assign pix       = offset_q + PIX_W'(col_q);
    assign glyph_idx = ADDR_W'(pix >> GCOL_W);
    assign glyph     = front_q[glyph_idx];

    matrix_glyph_rom u_rom (
        .glyph_i (glyph),
        .gcol_i  (pix[2:0]),
        .row_o   (rom_row)
    );

    // The last phase can never satisfy phase < brightness, giving the blank slot.
    assign col_active = (phase_q < bright_l_q);

    always_comb begin
        col_onehot = '0;
        row_d      = '0;
        if (col_active) begin
            col_onehot = NCOL'(1) << col_q;
            row_d      = rom_row;
        end
        column_d = COL_ACT_LOW ? ~col_onehot : col_onehot;
    end

    always_comb begin
        phase_d = phase_q;
        col_d   = col_q;
        if (CE) begin
            phase_d = phase_q + PWM_W'(1);
            if (phase_q == PH_MAX) begin
                col_d = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        offset_d = offset_q;
        fdiv_d   = fdiv_q;
        if (boundary) begin
            if (scroll_en_l_q) begin
                if (fdiv_q == FDIV_MAX) begin
                    fdiv_d   = '0;
                    offset_d = scroll_dir_l_q ? offset_q - PIX_W'(1)
                                              : offset_q + PIX_W'(1);
                end else begin
                    fdiv_d = fdiv_q + FDIV_W'(1);
                end
            end else begin
                offset_d = '0;
                fdiv_d   = '0;
            end
        end
    end

    // Copy consumes the registered flag, so a commit on the boundary waits a frame.
    assign pending_d = (boundary && pending_q) ? 1'b0 : (pending_q || commit);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q        <= '0;
            col_q          <= '0;
            offset_q       <= '0;
            fdiv_q         <= '0;
            pending_q      <= 1'b0;
            bright_l_q     <= PH_MAX;
            scroll_en_l_q  <= 1'b0;
            scroll_dir_l_q <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                front_q[i] <= '0;
                back_q[i]  <= '0;
            end
            column_q       <= COL_OFF;
            row_q          <= '0;
            frame_tick_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            col_q        <= col_d;
            offset_q     <= offset_d;
            fdiv_q       <= fdiv_d;
            pending_q    <= pending_d;
            if (boundary) begin
                bright_l_q     <= brightness;
                scroll_en_l_q  <= scroll_en;
                scroll_dir_l_q <= scroll_dir;
                if (pending_q) begin
                    front_q <= back_q;
                end
            end
            if (wr_en) begin
                back_q[wr_addr] <= wr_data;
            end
            column_q     <= column_d;
            row_q        <= row_d;
            frame_tick_q <= boundary;
        end
    end

    assign column     = column_q;
    assign row        = row_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_matrix_scroll_disp.sv
// Self-checking bench for matrix_scroll_disp against a frame-position model.
module tb_matrix_scroll_disp;

    localparam int NCOL = 8, MSG_LEN = 4, PWM_W = 2, SCROLL_DIV = 2;
    localparam int NPH = 4, FRAME = NCOL * NPH, PIXN = MSG_LEN * 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       CE = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       scroll_en = 1'b0;
    logic       scroll_dir = 1'b0;
    logic [1:0] brightness = 2'd3;
    logic [7:0] column;
    logic [7:0] row;
    logic       frame_tick;
    logic       pending;

    int total = 0;
    int bad = 0;

    matrix_scroll_disp #(
        .NCOL(NCOL), .MSG_LEN(MSG_LEN), .PWM_W(PWM_W),
        .SCROLL_DIV(SCROLL_DIV), .COL_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .CE(CE), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .scroll_en(scroll_en),
        .scroll_dir(scroll_dir), .brightness(brightness), .column(column),
        .row(row), .frame_tick(frame_tick), .pending(pending)
    );

    always #5 clk = ~clk;

    logic [7:0] font [16][8] = '{
        '{8'h00, 8'h3C, 8'h42, 8'h81, 8'h81, 8'h42, 8'h3C, 8'h00},
        '{8'h00, 8'h04, 8'h02, 8'h81, 8'hFF, 8'h80, 8'h80, 8'h00},
        '{8'h00, 8'hC2, 8'hA1, 8'h91, 8'h89, 8'h86, 8'h00, 8'h00},
        '{8'h00, 8'h42, 8'h81, 8'h89, 8'h89, 8'h76, 8'h00, 8'h00},
        '{8'h00, 8'h30, 8'h28, 8'h24, 8'h22, 8'hFF, 8'h20, 8'h00},
        '{8'h00, 8'h4F, 8'h89, 8'h89, 8'h89, 8'h71, 8'h00, 8'h00},
        '{8'h00, 8'h7E, 8'h89, 8'h89, 8'h89, 8'h72, 8'h00, 8'h00},
        '{8'h00, 8'h01, 8'h01, 8'hE1, 8'h11, 8'h09, 8'h07, 8'h00},
        '{8'h00, 8'h76, 8'h89, 8'h89, 8'h89, 8'h76, 8'h00, 8'h00},
        '{8'h00, 8'h4E, 8'h91, 8'h91, 8'h91, 8'h7E, 8'h00, 8'h00},
        '{8'h00, 8'hFE, 8'h11, 8'h11, 8'h11, 8'hFE, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h89, 8'h89, 8'h89, 8'h76, 8'h00, 8'h00},
        '{8'h00, 8'h7E, 8'h81, 8'h81, 8'h81, 8'h42, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h81, 8'h81, 8'h42, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h89, 8'h89, 8'h89, 8'h81, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h09, 8'h09, 8'h09, 8'h01, 8'h00, 8'h00}
    };

    // Model: position in the frame in CE ticks, plus message/scroll state.
    int m_tick, m_off, m_fdiv, m_bright, m_scr, m_dir, m_pend;
    int m_front [MSG_LEN];
    int m_back  [MSG_LEN];
    logic [7:0] exp_col, exp_row;
    logic       exp_ft, exp_pend;

    task automatic model_edge();
        int ph, c, pix;
        bit act, bnd;
        if (rst) begin
            m_tick = 0; m_off = 0; m_fdiv = 0; m_bright = NPH - 1;
            m_scr = 0; m_dir = 0; m_pend = 0;
            for (int i = 0; i < MSG_LEN; i++) begin
                m_front[i] = 0;
                m_back[i] = 0;
            end
            exp_col = 8'hFF; exp_row = 8'h00; exp_ft = 1'b0; exp_pend = 1'b0;
            return;
        end
        ph  = m_tick % NPH;
        c   = m_tick / NPH;
        act = (ph < m_bright);
        pix = (m_off + c) % PIXN;
        exp_col = act ? (8'hFF ^ (8'h01 << c)) : 8'hFF;
        exp_row = act ? font[m_front[pix / 8]][pix % 8] : 8'h00;
        bnd = CE && (m_tick == FRAME - 1);
        exp_ft = bnd;
        if (bnd) begin
            if (m_scr != 0) begin
                if (m_fdiv == SCROLL_DIV - 1) begin
                    m_fdiv = 0;
                    m_off = (m_dir != 0) ? (m_off + PIXN - 1) % PIXN : (m_off + 1) % PIXN;
                end else begin
                    m_fdiv = m_fdiv + 1;
                end
            end else begin
                m_off = 0;
                m_fdiv = 0;
            end
            m_scr = int'(scroll_en);
            m_dir = int'(scroll_dir);
            m_bright = int'(brightness);
        end
        if (bnd && m_pend != 0) begin
            m_front = m_back;
            m_pend = 0;
        end else if (commit) begin
            m_pend = 1;
        end
        if (CE) m_tick = (m_tick + 1) % FRAME;
        if (wr_en) m_back[wr_addr] = int'(wr_data);
        exp_pend = (m_pend != 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (column !== 8'hFF || row !== 8'h00 || pending !== 1'b0 || frame_tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_init col=%h/ff row=%h/00 pend=%b/0 ft=%b/0", column, row, pending, frame_tick);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < $urandom_range(40, 10); i++) begin
            tick();
            total++;
            if ({column, row, frame_tick, pending} !== {exp_col, exp_row, exp_ft, exp_pend}) begin
                bad++;
                $display("FAIL reset_scan col=%h/%h row=%h/%h ft=%b/%b pend=%b/%b",
                         column, exp_col, row, exp_row, frame_tick, exp_ft, pending, exp_pend);
            end
        end
        rst = 1'b1;
        commit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (column !== 8'hFF || row !== 8'h00 || pending !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid col=%h/ff row=%h/00 pend=%b/0", column, row, pending);
            end
        end
        rst = 1'b0;
        commit = 1'b0;
        tick();
        total++;
        if (column !== 8'hFE || row !== 8'h00 || pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_release col=%h/fe row=%h/00 pend=%b/0", column, row, pending);
        end
    endtask

    task automatic test_static();
        bit seen;
        int hit1, hit4;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd1;
        tick();
        wr_en = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            total++;
            if ((frame_tick ? 1'b0 : 1'b1) !== pending) begin
                bad++;
                $display("FAIL static_pending ft=%b pend=%b/%b", frame_tick, pending, ~frame_tick);
            end
            seen = frame_tick;
            if (!seen) tick();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL static_timeout frame_tick=0/1");
        end
        hit1 = 0; hit4 = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            total++;
            if ({column, row, frame_tick, pending} !== {exp_col, exp_row, exp_ft, exp_pend}) begin
                bad++;
                $display("FAIL static_scan col=%h/%h row=%h/%h ft=%b/%b pend=%b/%b",
                         column, exp_col, row, exp_row, frame_tick, exp_ft, pending, exp_pend);
            end
            if (column == 8'hFD) begin
                hit1++;
                total++;
                if (row !== 8'h04) begin
                    bad++;
                    $display("FAIL static_col1 row=%h/04", row);
                end
            end
            if (column == 8'hEF) begin
                hit4++;
                total++;
                if (row !== 8'hFF) begin
                    bad++;
                    $display("FAIL static_col4 row=%h/ff", row);
                end
            end
        end
        total++;
        if (hit1 != 3 || hit4 != 3) begin
            bad++;
            $display("FAIL static_dwell hits=%0d,%0d/3,3", hit1, hit4);
        end
    endtask

    task automatic test_brightness();
        int levels [3] = '{1, 3, 0};
        bit seen;
        int on_cnt;
        for (int i = 0; i < MSG_LEN; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 4'($urandom_range(15, 0));
            tick();
        end
        wr_en = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < $urandom_range(20, 3); i++) tick();
            brightness = 2'(levels[l]);
            seen = 1'b0;
            for (int i = 0; i < 2 * FRAME && !seen; i++) begin
                tick();
                total++;
                if ({column, row, frame_tick, pending} !== {exp_col, exp_row, exp_ft, exp_pend}) begin
                    bad++;
                    $display("FAIL bright_mid col=%h/%h row=%h/%h ft=%b/%b pend=%b/%b",
                             column, exp_col, row, exp_row, frame_tick, exp_ft, pending, exp_pend);
                end
                seen = frame_tick;
            end
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL bright_timeout frame_tick=0/1");
            end
            on_cnt = 0;
            for (int i = 0; i < FRAME; i++) begin
                tick();
                if (column != 8'hFF) on_cnt++;
                total++;
                if ({column, row} !== {exp_col, exp_row} || (column == 8'hFF && row != 8'h00)) begin
                    bad++;
                    $display("FAIL bright_scan lvl=%0d col=%h/%h row=%h/%h", levels[l], column, exp_col, row, exp_row);
                end
            end
            total++;
            if (on_cnt != levels[l] * NCOL) begin
                bad++;
                $display("FAIL bright_duty lvl=%0d on=%0d/%0d", levels[l], on_cnt, levels[l] * NCOL);
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_scroll();
        for (int i = 0; i < MSG_LEN; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 4'($urandom_range(15, 0));
            tick();
        end
        wr_en = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int d = 0; d < 2; d++) begin
            scroll_en = 1'b1;
            scroll_dir = d[0];
            for (int i = 0; i < 66 * FRAME; i++) begin
                tick();
                total++;
                if ({column, row, frame_tick, pending} !== {exp_col, exp_row, exp_ft, exp_pend}) begin
                    bad++;
                    $display("FAIL scroll dir=%0d off=%0d col=%h/%h row=%h/%h ft=%b/%b",
                             d, m_off, column, exp_col, row, exp_row, frame_tick, exp_ft);
                end
            end
        end
        scroll_en = 1'b0;
        scroll_dir = 1'b0;
    endtask

    task automatic test_ce_gating();
        int last_ft;
        int n_ft;
        logic [7:0] prev_col, prev_row;
        bit prev_ce;
        last_ft = -1; n_ft = 0;
        prev_col = column; prev_row = row; prev_ce = 1'b1;
        for (int i = 0; i < 400; i++) begin
            CE = (i % 4 == 0);
            wr_en = !CE && ($urandom_range(3, 0) == 0);
            wr_addr = 2'($urandom_range(3, 0));
            wr_data = 4'($urandom_range(15, 0));
            commit = !CE && ($urandom_range(15, 0) == 0);
            tick();
            total++;
            if ({column, row, frame_tick, pending} !== {exp_col, exp_row, exp_ft, exp_pend}) begin
                bad++;
                $display("FAIL ce_scan col=%h/%h row=%h/%h ft=%b/%b pend=%b/%b",
                         column, exp_col, row, exp_row, frame_tick, exp_ft, pending, exp_pend);
            end
            if (!CE && !prev_ce) begin
                total++;
                if (column !== prev_col || row !== prev_row) begin
                    bad++;
                    $display("FAIL ce_hold col=%h/%h row=%h/%h", column, prev_col, row, prev_row);
                end
            end
            if (frame_tick) begin
                if (last_ft >= 0) begin
                    total++;
                    if (i - last_ft != 4 * FRAME) begin
                        bad++;
                        $display("FAIL ce_frame_len len=%0d/%0d", i - last_ft, 4 * FRAME);
                    end
                end
                last_ft = i;
                n_ft++;
            end
            prev_col = column; prev_row = row; prev_ce = CE;
        end
        total++;
        if (n_ft < 2) begin
            bad++;
            $display("FAIL ce_ticks count=%0d/>=2", n_ft);
        end
        CE = 1'b1; wr_en = 1'b0; commit = 1'b0;
    endtask

    task automatic test_commit_race();
        int hits;
        brightness = 2'd3; scroll_en = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) tick();
        while (m_tick != 2) tick();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h2;
        tick();
        wr_en = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        while (m_tick != FRAME - 1) tick();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hE;
        tick();
        wr_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (p == 1) begin
                while (m_tick != FRAME - 1) tick();
                commit = 1'b1;
                tick();
                commit = 1'b0;
                total++;
                if (pending !== 1'b1) begin
                    bad++;
                    $display("FAIL race_commit_set pend=%b/1", pending);
                end
            end
            hits = 0;
            for (int i = 0; i < FRAME; i++) begin
                tick();
                total++;
                if ({column, row, frame_tick, pending} !== {exp_col, exp_row, exp_ft, exp_pend}) begin
                    bad++;
                    $display("FAIL race_scan p=%0d col=%h/%h row=%h/%h pend=%b/%b",
                             p, column, exp_col, row, exp_row, pending, exp_pend);
                end
                if (column == 8'hFD) begin
                    hits++;
                    total++;
                    if (row !== ((p == 2) ? 8'hFF : 8'hC2)) begin
                        bad++;
                        $display("FAIL race_col1 p=%0d row=%h/%h", p, row, (p == 2) ? 8'hFF : 8'hC2);
                    end
                end
            end
            total++;
            if (hits != 3) begin
                bad++;
                $display("FAIL race_hits p=%0d hits=%0d/3", p, hits);
            end
        end
        total++;
        if (pending !== 1'b0) begin
            bad++;
            $display("FAIL race_pending_clear pend=%b/0", pending);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            CE = ($urandom_range(3, 0) != 0);
            wr_en = ($urandom_range(3, 0) == 0);
            wr_addr = 2'($urandom_range(3, 0));
            wr_data = 4'($urandom_range(15, 0));
            commit = ($urandom_range(15, 0) == 0);
            if ($urandom_range(31, 0) == 0) brightness = 2'($urandom_range(3, 0));
            if ($urandom_range(63, 0) == 0) scroll_en = ~scroll_en;
            if ($urandom_range(63, 0) == 0) scroll_dir = ~scroll_dir;
            tick();
            total++;
            if ({column, row, frame_tick, pending} !== {exp_col, exp_row, exp_ft, exp_pend}) begin
                bad++;
                $display("FAIL random col=%h/%h row=%h/%h ft=%b/%b pend=%b/%b",
                         column, exp_col, row, exp_row, frame_tick, exp_ft, pending, exp_pend);
            end
        end
        CE = 1'b1; wr_en = 1'b0; commit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_brightness();
        test_scroll();
        test_ce_gating();
        test_commit_race();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time=%0t limit=5000000", $time);
        $fatal(1);
    end

endmodule
